// File: rtl/capture_ctrl.sv
// Sequences one ADC capture: arm, wait for a trigger edge or auto-trigger, wait a sample offset,
// then hold adc_capture_go_o until the FIFO path reports stop.
module capture_ctrl #(
  parameter int unsigned OFFSET_W     = 32,
  parameter int unsigned TIMEOUT_W    = 32,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                 adc_sampleclk,
  input  logic                 reset_n,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 trigger_i,
  input  logic                 trig_level_i,
  input  logic [OFFSET_W-1:0]  offset_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 adc_capture_stop_i,
  output logic                 adc_capture_go_o,
  output logic                 adc_trig_status_o,
  output logic                 armed_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timed_out_o
);

  localparam int unsigned BlankW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [BlankW-1:0] BlankMax = BlankW'(BLANK_CYCLES);

  typedef enum logic [2:0] {StIdle, StArmed, StDelay, StCapture, StDone} state_e;

  state_e               state_q;
  logic                 trig_d_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic [OFFSET_W-1:0]  dly_cnt_q;
  logic [OFFSET_W-1:0]  offset_q;
  logic [BlankW-1:0]    blank_cnt_q;
  logic                 go_q;
  logic                 trig_status_q;
  logic                 timed_out_q;

  logic trig_act;
  logic trig_edge;
  logic tmo_hit;
  logic dly_hit;
  logic blank_done;

  assign trig_act   = trig_level_i ? trigger_i : ~trigger_i;
  assign trig_edge  = trig_act & ~trig_d_q;
  assign tmo_hit    = (timeout_i != '0) && (tmo_cnt_q == timeout_i - TIMEOUT_W'(1));
  assign dly_hit    = (dly_cnt_q == offset_q - OFFSET_W'(1));
  assign blank_done = (blank_cnt_q == BlankMax);

  always_ff @(posedge adc_sampleclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      trig_d_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      dly_cnt_q     <= '0;
      offset_q      <= '0;
      blank_cnt_q   <= '0;
      go_q          <= 1'b0;
      trig_status_q <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      trig_d_q <= trig_act;
      if (abort_i) begin
        state_q       <= StIdle;
        go_q          <= 1'b0;
        trig_status_q <= 1'b0;
        tmo_cnt_q     <= '0;
        dly_cnt_q     <= '0;
        blank_cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle, StDone: begin
            if (arm_i) begin
              state_q       <= StArmed;
              // Pretend the level was already active so a pre-existing level cannot fire.
              trig_d_q      <= 1'b1;
              timed_out_q   <= 1'b0;
              trig_status_q <= 1'b0;
              tmo_cnt_q     <= '0;
            end
          end
          StArmed: begin
            if (trig_edge || tmo_hit) begin
              trig_status_q <= 1'b1;
              timed_out_q   <= ~trig_edge;
              offset_q      <= offset_i;
              dly_cnt_q     <= '0;
              blank_cnt_q   <= '0;
              if (offset_i != '0) begin
                state_q <= StDelay;
              end else begin
                state_q <= StCapture;
                go_q    <= 1'b1;
              end
            end else if (tmo_cnt_q != '1) begin
              tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
            end
          end
          StDelay: begin
            if (dly_hit) begin
              state_q     <= StCapture;
              go_q        <= 1'b1;
              blank_cnt_q <= '0;
            end else if (dly_cnt_q != '1) begin
              dly_cnt_q <= dly_cnt_q + OFFSET_W'(1);
            end
          end
          StCapture: begin
            // The FIFO stop flag lags go by a cycle, so ignore it while blanking.
            if (!blank_done) begin
              blank_cnt_q <= blank_cnt_q + BlankW'(1);
            end else if (adc_capture_stop_i) begin
              state_q <= StDone;
              go_q    <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign adc_capture_go_o  = go_q;
  assign adc_trig_status_o = trig_status_q;
  assign armed_o           = (state_q == StArmed);
  assign busy_o            = (state_q == StArmed) || (state_q == StDelay) ||
                             (state_q == StCapture);
  assign done_o            = (state_q == StDone);
  assign timed_out_o       = timed_out_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: runs are predicted from trigger/stop waveforms up front and
// a monitor checks every go pulse against the queued prediction.
module tb_capture_ctrl;
  localparam int B = 2;
  localparam int L = 160;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0, abort = 1'b0, trig = 1'b0, lvl = 1'b1, stop = 1'b0;
  logic [31:0] offset = '0, tmo = '0;
  logic        go, tstat, armed, busy, done, tout;

  capture_ctrl #(.OFFSET_W(32), .TIMEOUT_W(32), .BLANK_CYCLES(B)) dut (
    .adc_sampleclk     (clk),
    .reset_n           (rst_n),
    .arm_i             (arm),
    .abort_i           (abort),
    .trigger_i         (trig),
    .trig_level_i      (lvl),
    .offset_i          (offset),
    .timeout_i         (tmo),
    .adc_capture_stop_i(stop),
    .adc_capture_go_o  (go),
    .adc_trig_status_o (tstat),
    .armed_o           (armed),
    .busy_o            (busy),
    .done_o            (done),
    .timed_out_o       (tout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int rise; int len; bit to;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int   errors = 0, checks = 0, go_rises = 0, rise_cyc = 0;
  bit   mon_en = 1'b0;
  logic go_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops one prediction per completed go pulse.
  always @(negedge clk) begin
    if (go === 1'b1 && go_prev !== 1'b1) begin
      go_rises++;
      rise_cyc = cyc;
      if (mon_en && sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_go: go rose at cycle %0d with nothing queued", cyc);
      end
    end
    if (go !== 1'b1 && go_prev === 1'b1 && mon_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL go_fall: go fell at cycle %0d with nothing queued", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("go_rise_cycle", rise_cyc, mon_e.rise);
        check("go_length", cyc - rise_cyc, mon_e.len);
        check("timed_out", tout, mon_e.to);
        check("done_at_fall", done, 1);
        check("trig_status_at_fall", tstat, 1);
      end
    end
    go_prev = go;
  end

  task automatic step(input bit a, input bit ab, input bit t);
    @(posedge clk);
    #1;
    arm = a;
    abort = ab;
    trig = t;
  endtask

  // One arm-to-done sequence. t1/t2 force trigger toggles at those cycles after arm;
  // stop_k: -1 random stop, -2 stop always high, else a single stop pulse at that cycle.
  task automatic run_one(input bit lv, input int off, input int to_val, input bit tinit,
                         input int t1, input int t2, input bit rnd, input int stop_k);
    bit   tw[L];
    bit   act[L];
    bit   sw[L];
    int   kt, rise, len, fall_k, a;
    bit   auto_t;
    exp_t e;
    tw[0] = tinit;
    for (int k = 1; k < L; k++) begin
      tw[k] = tw[k-1];
      if (k == t1 || k == t2) tw[k] = ~tw[k];
      if (rnd && k < 40 && $urandom_range(0, 5) == 0) tw[k] = ~tw[k];
    end
    for (int k = 0; k < L; k++) begin
      act[k] = lv ? tw[k] : ~tw[k];
      if (stop_k == -2) sw[k] = 1'b1;
      else if (stop_k == -1) sw[k] = ($urandom_range(0, 3) == 0);
      else sw[k] = (k == stop_k);
    end
    sw[L-1] = 1'b1;
    // The first armed cycle cannot see an edge; a tie with the timeout goes to the edge.
    kt = -1;
    auto_t = 1'b0;
    for (int k = 2; k < L; k++) begin
      if (act[k] && !act[k-1]) begin
        kt = k;
        break;
      end
    end
    if (to_val != 0 && (kt < 0 || kt > to_val)) begin
      kt = to_val;
      auto_t = 1'b1;
    end
    rise = -1;
    len = 0;
    fall_k = L;
    if (kt >= 0) begin
      rise = kt + 1 + off;
      for (int j = B; rise + j < L; j++) begin
        if (sw[rise + j]) begin
          len = j + 1;
          break;
        end
      end
      fall_k = rise + len;
    end
    a = 0;
    for (int k = 0; k < L; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        a = cyc;
        if (kt >= 0) begin
          e.rise = a + rise;
          e.len = len;
          e.to = auto_t;
          sb.push_back(e);
        end
      end
      arm    = (k == 0) || (k < fall_k && $urandom_range(0, 7) == 0);
      abort  = 1'b0;
      trig   = tw[k];
      stop   = sw[k];
      lvl    = lv;
      tmo    = to_val;
      offset = (kt < 0 || k <= kt) ? off : $urandom;
      if (k == 1) begin
        check("armed_after_arm", armed, 1);
        check("trig_status_cleared_on_arm", tstat, 0);
      end
      if (kt >= 0 && k == kt + 1) begin
        check("busy_after_trigger", busy, 1);
        check("trig_status_after_trigger", tstat, 1);
      end
    end
    @(posedge clk);
    #1;
    arm = 1'b0;
    stop = 1'b0;
    if (kt < 0) begin
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("idle_after_abort_armed", {armed, busy}, 0);
    end else begin
      check("done_held", done, 1);
    end
  endtask

  int r0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {go, tstat, armed, busy, done, tout}, 0);
    rst_n = 1'b1;

    // Reset asserted mid-capture drops everything immediately.
    lvl = 1'b1; offset = '0; tmo = '0; stop = 1'b0;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 20 && go !== 1'b1; i++) step(0, 0, 1);
    check("go_before_reset", go, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", {go, busy, done}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1);
    check("idle_after_reset", {armed, busy, tstat}, 0);

    // Abort during DELAY.
    r0 = go_rises;
    offset = 32'd5;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    check("in_delay", busy, 1);
    step(0, 1, 1);
    repeat (15) step(0, 0, 1);
    check("abort_delay_no_go", go_rises, r0);
    check("abort_delay_idle", {busy, tstat}, 0);

    // Abort in the same cycle as the edge.
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    repeat (15) step(0, 0, 1);
    check("abort_edge_no_go", go_rises, r0);
    check("abort_edge_idle", {armed, busy, tstat}, 0);

    // timeout=0 with the level already active: never fires.
    offset = '0;
    step(1, 0, 1);
    repeat (10000) step(0, 0, 1);
    check("no_timeout_still_armed", armed, 1);
    check("no_timeout_no_go", go_rises, r0);
    step(0, 1, 1);
    step(0, 0, 1);
    check("idle_after_long_abort", armed, 0);

    mon_en = 1'b1;
    run_one(1'b1, 0, 0, 1'b0, 5, -1, 1'b0, 15);
    run_one(1'b0, 5, 0, 1'b0, 3, 8, 1'b0, -1);
    run_one(1'b1, 0, 100, 1'b1, -1, -1, 1'b0, -1);
    run_one(1'b1, 3, 0, 1'b0, 4, -1, 1'b0, -2);
    for (int n = 0; n < 30; n++) begin
      run_one(1'($urandom_range(0, 1)), $urandom_range(0, 6),
              ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 30),
              1'($urandom_range(0, 1)), -1, -1, 1'b1,
              ($urandom_range(0, 4) == 0) ? -2 : -1);
    end
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
